// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and load/store
// requesters: one outstanding transaction, grant lock while waiting for accept.
module sram_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_wr,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_addr_ok,
  input  logic                m_data_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  // owner and round-robin pointer: 0 = inst side, 1 = data side
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;

  logic both_req;
  logic winner;
  logic sel;
  logic req_act;
  logic hs;
  logic rsp;

  always_comb begin
    both_req = i_req & d_req;
    if (both_req) winner = DATA_PRIO ? 1'b1 : rr_q;
    else          winner = d_req;

    // In IDLE the grant follows the live arbitration; otherwise it is frozen.
    sel = (state_q == S_IDLE) ? winner : owner_q;

    req_act = 1'b0;
    case (state_q)
      S_IDLE:  req_act = i_req | d_req;
      S_LOCK:  req_act = sel ? d_req : i_req;
      default: req_act = 1'b0;
    endcase
    if (reset) req_act = 1'b0;

    hs  = req_act & m_addr_ok;
    rsp = (state_q == S_WAIT) & m_data_ok & ~reset;

    m_req     = req_act;
    m_wr      = req_act & sel & d_wr;
    m_wstrb   = (req_act & sel) ? d_wstrb : '0;
    m_wdata   = (req_act & sel) ? d_wdata : '0;
    m_addr    = req_act ? (sel ? d_addr : i_addr) : '0;

    i_addr_ok = hs & ~sel;
    d_addr_ok = hs & sel;
    i_data_ok = rsp & ~owner_q;
    d_data_ok = rsp & owner_q;
    i_rdata   = i_data_ok ? m_rdata : '0;
    d_rdata   = d_data_ok ? m_rdata : '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (req_act) begin
          owner_d = winner;
          state_d = m_addr_ok ? S_WAIT : S_LOCK;
        end
      end
      S_LOCK: begin
        if (hs) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Responses outside WAIT are strays and never reach this branch.
        if (m_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The loser of a contested handshake wins the next tie.
    if (hs && both_req) rr_d = ~sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

endmodule
